// File: rtl/mem_stage.sv
// MEM pipeline stage: word-organised big-endian data memory with combinational
// loads, edge-committed byte/half/word stores, misalignment tracking and a store counter.
module mem_stage #(
    parameter int DEPTH = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    output logic [31:0] Wdata,
    output logic        AdrErr,
    output logic [15:0] StoreCnt
);

    localparam int AW = $clog2(DEPTH * 4);
    localparam int IW = AW - 2;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic [31:0]   mem [DEPTH];

    logic [5:0]    opcode;
    logic [AW-1:0] addr;
    logic [IW-1:0] word_idx;
    logic [1:0]    offset;

    logic          is_load;
    logic          is_store;
    logic          acc_byte;
    logic          acc_half;
    logic          acc_word;
    logic          load_signed;
    logic          misaligned;
    logic          store_commit;

    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   wr_mask;
    logic [31:0]   wr_data;

    logic          unused_bits;

    assign opcode   = Ins[31:26];
    assign addr     = Result[AW-1:0];
    assign word_idx = addr[AW-1:2];
    assign offset   = addr[1:0];
    assign rd_word  = mem[word_idx];

    // Upper address bits are ignored so accesses wrap modulo the memory size.
    assign unused_bits = ^{Ins[25:0], Result[31:AW]};

    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        acc_byte    = 1'b0;
        acc_half    = 1'b0;
        acc_word    = 1'b0;
        load_signed = 1'b0;
        case (opcode)
            OP_LB:  begin is_load  = 1'b1; acc_byte = 1'b1; load_signed = 1'b1; end
            OP_LH:  begin is_load  = 1'b1; acc_half = 1'b1; load_signed = 1'b1; end
            OP_LW:  begin is_load  = 1'b1; acc_word = 1'b1; end
            OP_LBU: begin is_load  = 1'b1; acc_byte = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; acc_half = 1'b1; end
            OP_SB:  begin is_store = 1'b1; acc_byte = 1'b1; end
            OP_SH:  begin is_store = 1'b1; acc_half = 1'b1; end
            OP_SW:  begin is_store = 1'b1; acc_word = 1'b1; end
            default: ;
        endcase
    end

    assign misaligned   = (acc_half & offset[0]) | (acc_word & (offset != 2'b00));
    assign store_commit = is_store & ~misaligned;

    // Big-endian lanes: byte offset 0 is the most significant byte of the word.
    always_comb begin
        rd_byte = rd_word[7:0];
        case (offset)
            2'd0:    rd_byte = rd_word[31:24];
            2'd1:    rd_byte = rd_word[23:16];
            2'd2:    rd_byte = rd_word[15:8];
            default: rd_byte = rd_word[7:0];
        endcase
        rd_half = offset[1] ? rd_word[15:0] : rd_word[31:16];
    end

    always_comb begin
        Wdata = Result;
        if (is_load) begin
            if (misaligned) begin
                Wdata = 32'h0;
            end else if (acc_byte) begin
                Wdata = load_signed ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            end else if (acc_half) begin
                Wdata = load_signed ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            end else begin
                Wdata = rd_word;
            end
        end
    end

    // Replicate the store data across all lanes and let the mask pick the target lanes.
    always_comb begin
        wr_mask = 32'hFFFF_FFFF;
        wr_data = Rdata2;
        if (acc_byte) begin
            wr_mask = 32'hFF00_0000 >> {offset, 3'b000};
            wr_data = {4{Rdata2[7:0]}};
        end else if (acc_half) begin
            wr_mask = offset[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
            wr_data = {2{Rdata2[15:0]}};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (store_commit) begin
            mem[word_idx] <= (rd_word & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // AdrErr is sticky until reset; StoreCnt saturates rather than wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            AdrErr   <= 1'b0;
            StoreCnt <= 16'h0;
        end else begin
            if (misaligned) begin
                AdrErr <= 1'b1;
            end
            if (store_commit && (StoreCnt != 16'hFFFF)) begin
                StoreCnt <= StoreCnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit data-memory words; the address range is DEPTH*4 bytes.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Ins, input, 32 bits: the current instruction; opcode = Ins[31:26].
REQ-005 SHALL have port Result, input, 32 bits: the EX-stage ALU result, used as the byte address for loads and stores.
REQ-006 SHALL have port Rdata2, input, 32 bits: the rt register value, used as store data.
REQ-007 SHALL have port Wdata, output, 32 bits: the write-back value (load data, or Result passed through).
REQ-008 SHALL have port AdrErr, output, 1 bit: sticky misaligned-access flag.
REQ-009 SHALL have port StoreCnt, output, 16 bits: count of committed stores.

Function
REQ-010 SHALL decode memory opcodes as follows: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
REQ-011 SHALL form the byte address from Result[log2(DEPTH*4)-1:0]; higher bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-012 SHALL use word index = address[..:2] and big-endian byte lanes: offset 0 is bits 31:24, offset 3 is bits 7:0; halfword offset 0 is bits 31:16, offset 2 is bits 15:0.
REQ-013 SHALL read loads combinationally, with zero latency: Wdata reflects memory contents in the same cycle Ins/Result are presented.
REQ-014 SHALL sign-extend LB/LH results to 32 bits and zero-extend LBU/LHU results; LW returns the full word.
REQ-015 SHALL, for non-memory opcodes, drive Wdata = Result combinationally.
REQ-016 SHALL, for stores, drive Wdata = Result; a store has no write-back value.
REQ-017 SHALL commit stores at the rising CLK edge, modifying only the addressed lanes:
- SB writes Rdata2[7:0].
- SH writes Rdata2[15:0].
- SW writes Rdata2.
- All other bytes of the word are preserved.
REQ-018 SHALL treat an access as misaligned when it is LH/LHU/SH with address[0]=1, or LW/SW with address[1:0]≠0.
REQ-019 SHALL, for a misaligned load, drive Wdata = 0.
REQ-020 SHALL suppress the memory write for a misaligned store.
REQ-021 SHALL, on any misaligned access, set AdrErr at the next edge; AdrErr stays 1 until RST.
REQ-022 SHALL increment StoreCnt by 1 at each edge where an aligned store commits; StoreCnt saturates at 0xFFFF and does not wrap.
REQ-023 SHALL, when a load follows a store to the same word, return the updated data on the load cycle, since the store committed at the preceding edge.

Reset
REQ-024 SHALL, at a rising edge with RST=1, clear all memory words to 0 and set AdrErr=0 and StoreCnt=0.
REQ-025 SHALL give RST priority over a simultaneous store: no write occurs and the counter is not incremented.
REQ-026 SHALL keep Wdata combinational during reset; after reset, loads return 0.

Verification
REQ-027 SHALL verify SW then LW: SW with Result=0x10, Rdata2=0x12345678, clock; then LW with Result=0x10 -> Wdata=0x12345678, StoreCnt=1.
REQ-028 SHALL verify byte/half loads: after the store in REQ-027, LB @0x13 -> 0x00000078; LB @0x10 -> 0x00000012; then SB 0xF0 @0x11 -> LB @0x11=0xFFFFFFF0, LBU @0x11=0x000000F0, LW @0x10=0x12F05678.
REQ-029 SHALL verify halfword: SH 0x8001 @0x12 -> LH @0x12=0xFFFF8001, LHU @0x12=0x00008001, LW @0x10=0x12F08001.
REQ-030 SHALL verify misaligned accesses: SW @0x11 with Rdata2=0xDEADBEEF -> memory unchanged (LW @0x10 still 0x12F08001), AdrErr=1 after the edge, StoreCnt unchanged; LW @0x02 -> Wdata=0.
REQ-031 SHALL verify wrap and pass-through: with DEPTH=256, SW @0x400 writes word 0 (LW @0x0 matches); ADD Ins=0x00000020 with Result=0x8 -> Wdata=0x8.
REQ-032 SHALL verify reset against a store: RST=1 together with SW @0x20 -> after the edge LW @0x20=0, LW @0x10=0, AdrErr=0, StoreCnt=0.
